// File: rtl/load_align_unit_if.sv
// load_align_unit_if: the load request channel, the aligned data-memory
// read channel and the result channel of the load align unit, grouped
// into one bundle.
//   req_*      : load request (funct3 + byte address), valid/ready
//   mem_req_*  : word-aligned read request to data memory, valid/ready
//   mem_rsp_*  : read data returned by memory, valid pulse only
//   rsp_*      : extended load result or error, valid/ready
// The slave modport is the unit's view. The master modport is the view of
// the surrounding LSU, memory and consumer.
interface load_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_funct3, req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_ready,
        output req_ready, mem_req_valid, mem_req_addr,
        output rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_funct3, req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_ready,
        input  req_ready, mem_req_valid, mem_req_addr,
        input  rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit: sequential load extract/extend unit.
// Takes one load request at a time and issues one or two word-aligned
// memory reads. A load that crosses a word boundary needs two reads. The
// unit merges the beats, then extracts the addressed bytes and sign- or
// zero-extends them. The result, or an error for an illegal access, is
// returned over a valid/ready handshake.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - load_align_unit_if.slave (request, memory read and result channels)
// Parameters: XLEN (32/64), ADDR_W, MISALIGN_EN (1 = split misaligned loads).
module load_align_unit #(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int MISALIGN_EN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    load_align_unit_if.slave        bus
);
    localparam int WB = XLEN / 8;
    localparam int OB = $clog2(WB);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OB-1:0]     off_q, off_d;
    logic              cross_q, cross_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   beat0_q, beat0_d;
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [3:0]        size_s;
    logic [4:0]        end_s;
    logic              illegal_s;
    logic              misal_s;
    logic              cross_s;

    // Shift the two-beat window down to the addressed byte, then keep the
    // low 8*S bits. Bits above those are filled with the sign bit, or with
    // zero for the unsigned variants. Full-word loads pass through unchanged.
    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] merged,
                                                input logic [OB-1:0]     off,
                                                input logic [2:0]        f3);
        logic [2*XLEN-1:0] sh;
        logic [XLEN-1:0]   res;
        logic              sign;
        int                nbits;
        sh    = merged >> {off, 3'b000};
        nbits = int'(32'd8 << f3[1:0]);
        if (nbits > XLEN) begin
            nbits = XLEN;
        end else begin
            nbits = nbits;
        end
        case (f3[1:0])
            2'b00:   sign = sh[7];
            2'b01:   sign = sh[15];
            2'b10:   sign = sh[31];
            default: sign = sh[XLEN-1];
        endcase
        if (f3[2]) begin
            sign = 1'b0;
        end else begin
            sign = sign;
        end
        for (int i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? sh[i] : sign;
        end
        return res;
    endfunction

    // Classify the incoming request: access size, legality, misalignment and word crossing.
    always_comb begin
        size_s    = 4'd1 << bus.req_funct3[1:0];
        end_s     = {{(5-OB){1'b0}}, bus.req_addr[OB-1:0]} + {1'b0, size_s};
        cross_s   = (end_s > 5'(WB));
        misal_s   = (({{(4-OB){1'b0}}, bus.req_addr[OB-1:0]} & (size_s - 4'd1)) != 4'd0);
        illegal_s = (bus.req_funct3 == 3'b111) ||
                    (((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)) &&
                     (XLEN != 32'sd64));
    end

    // Next-state logic and next values of the datapath registers.
    always_comb begin
        state_d    = state_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        cross_d    = cross_q;
        mem_addr_d = mem_addr_q;
        beat0_d    = beat0_q;
        beat1_d    = beat1_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    funct3_d   = bus.req_funct3;
                    off_d      = bus.req_addr[OB-1:0];
                    cross_d    = cross_s;
                    mem_addr_d = {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                    beat0_d    = {XLEN{1'b0}};
                    beat1_d    = {XLEN{1'b0}};
                    rsp_data_d = {XLEN{1'b0}};
                    rsp_err_d  = 1'b0;
                    // Errors skip memory entirely and answer on the next cycle.
                    if (illegal_s || (misal_s && (MISALIGN_EN == 32'sd0))) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        state_d   = REQ0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ0: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT0;
                end else begin
                    state_d = REQ0;
                end
            end
            WAIT0: begin
                if (bus.mem_rsp_valid) begin
                    beat0_d = bus.mem_rsp_data;
                    if (cross_q) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(WB);
                        state_d    = REQ1;
                    end else begin
                        rsp_data_d = extract({{XLEN{1'b0}}, bus.mem_rsp_data}, off_q, funct3_q);
                        state_d    = RESP;
                    end
                end else begin
                    state_d = WAIT0;
                end
            end
            REQ1: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT1;
                end else begin
                    state_d = REQ1;
                end
            end
            WAIT1: begin
                if (bus.mem_rsp_valid) begin
                    beat1_d    = bus.mem_rsp_data;
                    rsp_data_d = extract({bus.mem_rsp_data, beat0_q}, off_q, funct3_q);
                    state_d    = RESP;
                end else begin
                    state_d = WAIT1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            off_q      <= {OB{1'b0}};
            cross_q    <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            beat0_q    <= {XLEN{1'b0}};
            beat1_q    <= {XLEN{1'b0}};
            rsp_data_q <= {XLEN{1'b0}};
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            cross_q    <= cross_d;
            mem_addr_q <= mem_addr_d;
            beat0_q    <= beat0_d;
            beat1_q    <= beat1_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == REQ0) || (state_q == REQ1);
    assign bus.mem_req_addr  = mem_addr_q;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (XLEN=32). dut0 supports misaligned
// loads and is served by a small memory model with selectable latency.
// dut1 has misaligned support disabled and must never touch memory.
module tb_load_align_unit;
    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_align_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bif0 ();
    load_align_unit_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bif1 ();

    load_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN_EN(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bif0.slave)
    );
    load_align_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MISALIGN_EN(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bif1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'h80FF_1234;
            32'h0000_0200: mem_word = 32'hAABB_CCDD;
            32'h0000_0204: mem_word = 32'h1122_3344;
            32'h0000_0300: mem_word = 32'h0000_0001;
            default:       mem_word = 32'hDEAD_BEEF;
        endcase
    endfunction

    // Memory model for dut0: latency 1 answers the cycle after the accepted request.
    int                mem_lat  = 1;
    int                pend_cnt = 0;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] req_log[$];
    int                bif1_reqs = 0;

    always @(posedge clk) begin
        bif0.mem_rsp_valid <= 1'b0;
        if (pend_cnt > 1) begin
            pend_cnt <= pend_cnt - 1;
        end else if (pend_cnt == 1) begin
            pend_cnt           <= 0;
            bif0.mem_rsp_valid <= 1'b1;
            bif0.mem_rsp_data  <= pend_data;
        end
        if (bif0.mem_req_valid && bif0.mem_req_ready) begin
            req_log.push_back(bif0.mem_req_addr);
            if (mem_lat <= 1) begin
                bif0.mem_rsp_valid <= 1'b1;
                bif0.mem_rsp_data  <= mem_word(bif0.mem_req_addr);
            end else begin
                pend_cnt  <= mem_lat - 1;
                pend_data <= mem_word(bif0.mem_req_addr);
            end
        end
        if (bif1.mem_req_valid) bif1_reqs <= bif1_reqs + 1;
    end

    // One load on dut0: latency counted in cycles after the accept edge.
    task automatic load0(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_lat,
                         input int n_reads, input logic [31:0] a0, input logic [31:0] a1);
        int lat;
        req_log.delete();
        @(negedge clk);
        check_eq({tag, "_req_ready"}, 64'(bif0.req_ready), 64'd1);
        bif0.req_valid  = 1'b1;
        bif0.req_funct3 = f3;
        bif0.req_addr   = addr;
        @(posedge clk);
        #1 bif0.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bif0.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_data"}, 64'(bif0.rsp_data), 64'(exp_data));
        check_eq({tag, "_err"}, 64'(bif0.rsp_err), 64'(exp_err));
        check_eq({tag, "_nreads"}, 64'(req_log.size()), 64'(n_reads));
        if (n_reads > 0 && req_log.size() > 0) check_eq({tag, "_addr0"}, 64'(req_log[0]), 64'(a0));
        if (n_reads > 1 && req_log.size() > 1) check_eq({tag, "_addr1"}, 64'(req_log[1]), 64'(a1));
        @(posedge clk);
        #1;
    endtask

    // Error request on dut1 (misaligned loads disabled): response one cycle after accept.
    task automatic err1(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        int lat;
        @(negedge clk);
        bif1.req_valid  = 1'b1;
        bif1.req_funct3 = f3;
        bif1.req_addr   = addr;
        @(posedge clk);
        #1 bif1.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bif1.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd1);
        check_eq({tag, "_data"}, 64'(bif1.rsp_data), 64'd0);
        check_eq({tag, "_err"}, 64'(bif1.rsp_err), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int lat;
        bif0.req_valid = 1'b0; bif0.req_funct3 = 3'b000; bif0.req_addr = 32'h0;
        bif0.mem_req_ready = 1'b1; bif0.rsp_ready = 1'b1;
        bif1.req_valid = 1'b0; bif1.req_funct3 = 3'b000; bif1.req_addr = 32'h0;
        bif1.mem_req_ready = 1'b1; bif1.mem_rsp_valid = 1'b0; bif1.mem_rsp_data = 32'h0;
        bif1.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_eq("rst_req_ready", 64'(bif0.req_ready), 64'd1);
        check_eq("rst_mem_req_valid", 64'(bif0.mem_req_valid), 64'd0);
        check_eq("rst_rsp_valid", 64'(bif0.rsp_valid), 64'd0);
        check_eq("rst_rsp_err", 64'(bif0.rsp_err), 64'd0);
        check_eq("rst_rsp_data", 64'(bif0.rsp_data), 64'd0);
        check_eq("rst1_req_ready", 64'(bif1.req_ready), 64'd1);

        // Byte/half extraction from word 0x80FF_1234 at 0x100.
        load0("lb_103",  3'b000, 32'h103, 32'hFFFF_FF80, 1'b0, 3, 1, 32'h100, 32'h0);
        load0("lbu_103", 3'b100, 32'h103, 32'h0000_0080, 1'b0, 3, 1, 32'h100, 32'h0);
        load0("lhu_102", 3'b101, 32'h102, 32'h0000_80FF, 1'b0, 3, 1, 32'h100, 32'h0);
        load0("lh_102",  3'b001, 32'h102, 32'hFFFF_80FF, 1'b0, 3, 1, 32'h100, 32'h0);
        load0("lw_100",  3'b010, 32'h100, 32'h80FF_1234, 1'b0, 3, 1, 32'h100, 32'h0);
        load0("lb_101",  3'b000, 32'h101, 32'h0000_0012, 1'b0, 3, 1, 32'h100, 32'h0);
        // Misaligned but inside one word: single read.
        load0("lh_101",  3'b001, 32'h101, 32'hFFFF_FF12, 1'b0, 3, 1, 32'h100, 32'h0);
        // Word-crossing loads: two reads, merged.
        load0("lw_203",  3'b010, 32'h203, 32'h2233_44AA, 1'b0, 5, 2, 32'h200, 32'h204);
        load0("lh_203",  3'b001, 32'h203, 32'h0000_44AA, 1'b0, 5, 2, 32'h200, 32'h204);
        // Illegal funct3 on XLEN=32.
        load0("f3_111",  3'b111, 32'h100, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        load0("f3_011",  3'b011, 32'h100, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);
        load0("f3_110",  3'b110, 32'h100, 32'h0, 1'b1, 1, 0, 32'h0, 32'h0);

        // Misalignment disabled: all of these are errors without a memory access.
        err1("m0_lw_202", 3'b010, 32'h202);
        err1("m0_lh_101", 3'b001, 32'h101);
        err1("m0_f3_111", 3'b111, 32'h100);
        err1("m0_f3_011", 3'b011, 32'h100);
        check_eq("m0_no_mem_req", 64'(bif1_reqs), 64'd0);

        // Backpressure on both the memory request and the result.
        req_log.delete();
        @(negedge clk);
        bif0.mem_req_ready = 1'b0;
        bif0.rsp_ready     = 1'b0;
        bif0.req_valid     = 1'b1;
        bif0.req_funct3    = 3'b010;
        bif0.req_addr      = 32'h100;
        @(posedge clk);
        #1 bif0.req_valid = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (!(bif0.mem_req_valid === 1'b1 && bif0.mem_req_addr === 32'h100 &&
                  bif0.req_ready === 1'b0)) bad++;
        end
        check_eq("bp_mem_req_hold", 64'(bad), 64'd0);
        bif0.mem_req_ready = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bif0.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check_eq("bp_rsp_seen", 64'(lat), 64'd2);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (!(bif0.rsp_valid === 1'b1 && bif0.rsp_data === 32'h80FF_1234 &&
                  bif0.rsp_err === 1'b0 && bif0.req_ready === 1'b0)) bad++;
            @(negedge clk);
        end
        check_eq("bp_rsp_hold", 64'(bad), 64'd0);
        bif0.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_rsp_retired", 64'(bif0.rsp_valid), 64'd0);
        check_eq("bp_req_ready_back", 64'(bif0.req_ready), 64'd1);
        check_eq("bp_nreads", 64'(req_log.size()), 64'd1);

        // Reset in WAIT0 while the memory response is still in flight.
        mem_lat = 2;
        @(negedge clk);
        bif0.req_valid  = 1'b1;
        bif0.req_funct3 = 3'b010;
        bif0.req_addr   = 32'h100;
        @(posedge clk);
        #1 bif0.req_valid = 1'b0;
        @(negedge clk);            // REQ0, accepted at the next edge
        @(negedge clk);            // WAIT0
        check_eq("rst_mid_in_wait0", 64'(bif0.mem_req_valid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_req_ready", 64'(bif0.req_ready), 64'd1);
        check_eq("rst_mid_rsp_data", 64'(bif0.rsp_data), 64'd0);
        check_eq("rst_mid_rsp_err", 64'(bif0.rsp_err), 64'd0);
        bad = 0;
        repeat (4) begin
            if (bif0.rsp_valid !== 1'b0 || bif0.mem_req_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        check_eq("rst_mid_no_rsp", 64'(bad), 64'd0);
        mem_lat = 1;
        load0("lw_300", 3'b010, 32'h300, 32'h0000_0001, 1'b0, 3, 1, 32'h300, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
